// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one table-memory port among NUM_REQ requesters.
// Every grant change passes through one idle cycle; long owners are preempted after HOLD_MAX cycles.
module mem_arb #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 16,
    parameter int ADDR_BUS = 32,
    parameter int DATA_BUS = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_ce_i,
    input  logic [NUM_REQ-1:0]                 req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_BUS-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][3:0]            req_width_i,
    input  logic [NUM_REQ-1:0][DATA_BUS-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    output logic [NUM_REQ-1:0]                 rvalid_o,
    output logic [DATA_BUS-1:0]                rdata_o,
    output logic                               mem_ce_o,
    output logic                               mem_we_o,
    output logic [ADDR_BUS-1:0]                mem_addr_o,
    output logic [3:0]                         mem_width_o,
    output logic [DATA_BUS-1:0]                mem_data_o,
    input  logic [DATA_BUS-1:0]                mem_data_i
);

    // state    | meaning
    // ARB_IDLE | no owner; arbitrate among pending requests
    // ARB_BUSY | owner drives the memory port
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    logic [0:0]         state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_owner_q, last_owner_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic               busy;
    logic               pick_valid;
    logic [OW-1:0]      pick_idx;
    logic [OW-1:0]      cand;
    logic               others_req;

    // First requester strictly after last_owner, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((int'(last_owner_q) + i) % NUM_REQ);
            if (!pick_valid && req_ce_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign busy       = (state_q == ARB_BUSY);
    assign others_req = |(req_ce_i & ~gnt_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_d        = gnt_q;
        if (state_q == ARB_IDLE) begin
            gnt_d = '0;
            if (pick_valid) begin
                state_d    = ARB_BUSY;
                owner_d    = pick_idx;
                gnt_d      = NUM_REQ'(1) << pick_idx;
                hold_cnt_d = '0;
            end
        end else begin
            if (!req_ce_i[owner_q] || (hold_cnt_q == HOLD_LAST && others_req)) begin
                state_d      = ARB_IDLE;
                gnt_d        = '0;
                last_owner_d = owner_q;
            end
            if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    assign mem_ce_o    = busy & req_ce_i[owner_q];
    assign mem_we_o    = busy & req_we_i[owner_q];
    assign mem_addr_o  = busy ? req_addr_i[owner_q]  : '0;
    assign mem_width_o = busy ? req_width_i[owner_q] : '0;
    assign mem_data_o  = busy ? req_data_i[owner_q]  : '0;

    // Read valid follows the access itself, not the grant, so a read in a released cycle still returns.
    always_comb begin
        rvalid_d = '0;
        if (mem_ce_o && !mem_we_o) begin
            rvalid_d = NUM_REQ'(1) << owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = mem_data_i;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a cycle table for basic grant/read/write behaviour,
// plus hand sequences for rotation, preemption and mid-burst reset.
module tb_mem_arb;

    logic             clk;
    logic             rst;
    logic [3:0]       req_ce_i;
    logic [3:0]       req_we_i;
    logic [3:0][31:0] req_addr_i;
    logic [3:0][3:0]  req_width_i;
    logic [3:0][31:0] req_data_i;
    logic [3:0]       gnt_o;
    logic [3:0]       rvalid_o;
    logic [31:0]      rdata_o;
    logic             mem_ce_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [3:0]       mem_width_o;
    logic [31:0]      mem_data_o;
    logic [31:0]      mem_data_i;

    int checks = 0;
    int errors = 0;

    mem_arb #(.NUM_REQ(4), .HOLD_MAX(16), .ADDR_BUS(32), .DATA_BUS(32)) dut (
        .clk(clk), .rst(rst),
        .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_width_i(req_width_i), .req_data_i(req_data_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  ce;
        logic [3:0]  we;
        logic [31:0] rd;
        logic [3:0]  gnt;
        logic        mce;
        logic        mwe;
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] wdata;
        logic [3:0]  rv;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [3:0] ce, logic [3:0] we, logic [31:0] rd, logic [3:0] gnt,
                                logic mce, logic mwe, logic [31:0] addr, logic [3:0] width,
                                logic [31:0] wdata, logic [3:0] rv);
        vec_t v;
        v.ce = ce; v.we = we; v.rd = rd; v.gnt = gnt; v.mce = mce; v.mwe = mwe;
        v.addr = addr; v.width = width; v.wdata = wdata; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, then the caller checks.
    task automatic cyc(input logic r, input logic [3:0] ce, input logic [3:0] we, input logic [31:0] rd);
        @(negedge clk);
        rst        = r;
        req_ce_i   = ce;
        req_we_i   = we;
        mem_data_i = rd;
        #1;
    endtask

    function automatic logic [3:0] exp_rot(int c);
        if (c % 17 == 0) return 4'b0000;
        return 4'b0001 << ((c / 17) % 4);
    endfunction

    function automatic logic [3:0] exp_pre(int c);
        if (c == 0) return 4'b0000;
        if (c <= 41) return 4'b0010;
        if (c == 42) return 4'b0000;
        if (c <= 58) return 4'b1000;
        if (c == 59) return 4'b0000;
        if (c <= 75) return 4'b0010;
        if (c == 76) return 4'b0000;
        return 4'b1000;
    endfunction

    initial begin
        logic [3:0] prev_gnt;

        rst = 1'b1; req_ce_i = '0; req_we_i = '0; mem_data_i = '0;
        req_addr_i  = {32'h0000_0010, 32'h0000_0040, 32'h0000_0104, 32'h0000_0100};
        req_width_i = {4'd4, 4'd3, 4'd2, 4'd1};
        req_data_i  = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};

        vecs[0]  = mk(4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);
        vecs[1]  = mk(4'h5, 4'h0, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);
        vecs[2]  = mk(4'h5, 4'h0, 32'h0,        4'h1, 1, 0, 32'h100, 4'd1, 32'hA0, 4'h0);
        vecs[3]  = mk(4'h5, 4'h0, 32'h1111_1111, 4'h1, 1, 0, 32'h100, 4'd1, 32'hA0, 4'h1);
        vecs[4]  = mk(4'h4, 4'h0, 32'h0,        4'h1, 0, 0, 32'h100, 4'd1, 32'hA0, 4'h1);
        vecs[5]  = mk(4'h4, 4'h0, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);
        vecs[6]  = mk(4'h4, 4'h0, 32'h0,        4'h4, 1, 0, 32'h40,  4'd3, 32'hA2, 4'h0);
        vecs[7]  = mk(4'h0, 4'h0, 32'hDEAD_BEEF, 4'h4, 0, 0, 32'h40,  4'd3, 32'hA2, 4'h4);
        vecs[8]  = mk(4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);
        vecs[9]  = mk(4'h1, 4'h0, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);
        vecs[10] = mk(4'h9, 4'h9, 32'h0,        4'h1, 1, 1, 32'h100, 4'd1, 32'hA0, 4'h0);
        vecs[11] = mk(4'h9, 4'h9, 32'h0,        4'h1, 1, 1, 32'h100, 4'd1, 32'hA0, 4'h0);
        vecs[12] = mk(4'h8, 4'h8, 32'h0,        4'h1, 0, 0, 32'h100, 4'd1, 32'hA0, 4'h0);
        vecs[13] = mk(4'h8, 4'h8, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);
        vecs[14] = mk(4'h8, 4'h8, 32'h0,        4'h8, 1, 1, 32'h10,  4'd4, 32'hA3, 4'h0);
        vecs[15] = mk(4'h0, 4'h0, 32'h0,        4'h8, 0, 0, 32'h10,  4'd4, 32'hA3, 4'h0);
        vecs[16] = mk(4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 32'h0,   4'd0, 32'h0,  4'h0);

        // Table: reset state, read latency, release, write isolation of a waiting requester.
        cyc(1'b1, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            cyc(1'b0, vecs[i].ce, vecs[i].we, vecs[i].rd);
            chk("tbl_gnt",    i, 32'(gnt_o),       32'(vecs[i].gnt));
            chk("tbl_mce",    i, 32'(mem_ce_o),    32'(vecs[i].mce));
            chk("tbl_mwe",    i, 32'(mem_we_o),    32'(vecs[i].mwe));
            chk("tbl_addr",   i, mem_addr_o,       vecs[i].addr);
            chk("tbl_width",  i, 32'(mem_width_o), 32'(vecs[i].width));
            chk("tbl_wdata",  i, mem_data_o,       vecs[i].wdata);
            chk("tbl_rvalid", i, 32'(rvalid_o),    32'(vecs[i].rv));
            chk("tbl_rdata",  i, rdata_o,          vecs[i].rd);
        end

        // Four continuous readers: 16-cycle holds separated by one idle cycle.
        cyc(1'b1, 4'h0, 4'h0, 32'h0);
        prev_gnt = 4'h0;
        for (int c = 0; c < 86; c++) begin
            cyc(1'b0, 4'hF, 4'h0, 32'(c));
            chk("rot_gnt",    c, 32'(gnt_o),    32'(exp_rot(c)));
            chk("rot_mce",    c, 32'(mem_ce_o), 32'(exp_rot(c) != 4'h0));
            chk("rot_rvalid", c, 32'(rvalid_o), 32'(prev_gnt));
            prev_gnt = exp_rot(c);
        end

        // Lone owner is never preempted; a newcomer forces release once the hold expires.
        cyc(1'b1, 4'h0, 4'h0, 32'h0);
        for (int c = 0; c < 81; c++) begin
            cyc(1'b0, (c >= 41) ? 4'b1010 : 4'b0010, 4'h0, 32'h0);
            chk("pre_gnt", c, 32'(gnt_o), 32'(exp_pre(c)));
            if (c == 41) begin
                chk("pre_last_mce",  c, 32'(mem_ce_o), 32'd1);
                chk("pre_last_addr", c, mem_addr_o,    32'h104);
            end
        end

        // Reset in the middle of requester 1's read burst.
        cyc(1'b1, 4'h0, 4'h0, 32'h0);
        cyc(1'b0, 4'b0010, 4'h0, 32'h0);
        chk("rst_gnt", 0, 32'(gnt_o), 32'h0);
        cyc(1'b0, 4'b0010, 4'h0, 32'h0);
        chk("rst_gnt", 1, 32'(gnt_o), 32'h2);
        cyc(1'b0, 4'b0010, 4'h0, 32'h0);
        chk("rst_rvalid", 2, 32'(rvalid_o), 32'h2);
        cyc(1'b1, 4'b0011, 4'h0, 32'h0);
        chk("rst_mce", 3, 32'(mem_ce_o), 32'd1);
        cyc(1'b0, 4'b0011, 4'h0, 32'h0);
        chk("rst_gnt",    4, 32'(gnt_o),    32'h0);
        chk("rst_mce",    4, 32'(mem_ce_o), 32'd0);
        chk("rst_rvalid", 4, 32'(rvalid_o), 32'h0);
        cyc(1'b0, 4'b0011, 4'h0, 32'h0);
        chk("rst_gnt",  5, 32'(gnt_o),      32'h1);
        chk("rst_addr", 5, mem_addr_o,      32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
